// File: rtl/ra1sh_pkg.sv
// Shared definitions for the ra1sh_v2 SRAM model: write-mode codes, clear FSM
// encoding and the per-lane byte merge used on partial writes.
package ra1sh_pkg;

  localparam int WM_WRITE_THROUGH = 0;
  localparam int WM_READ_FIRST    = 1;
  localparam int WM_NO_CHANGE     = 2;

  // Widest word the merge helper handles; callers zero-extend into it.
  localparam int MAX_BITS = 512;
  localparam int IDX_W    = $clog2(MAX_BITS);

  typedef logic [MAX_BITS-1:0] word_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_t;

  // Lane l covers bits [l*lane_w +: lane_w]; an active-low enable takes the new byte.
  function automatic word_t byte_merge(input word_t old_w, input word_t new_w,
                                       input word_t bwen, input int lane_w);
    word_t res;
    logic [IDX_W-1:0] lane;
    res = '0;
    for (int i = 0; i < MAX_BITS; i++) begin
      lane = IDX_W'(i / lane_w);
      res[IDX_W'(i)] = bwen[lane] ? old_w[IDX_W'(i)] : new_w[IDX_W'(i)];
    end
    return res;
  endfunction

endpackage

// File: rtl/ra1sh_v2_clr.sv
// Post-reset clear sequencer: sweeps every word address once, writing zero,
// then hands the array over to the user port.
module ra1sh_v2_clr
  import ra1sh_pkg::*;
#(
  parameter int WORD_DEPTH     = 8192,
  parameter int ADDR_WIDTH     = 13,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_we,
  output clr_state_t            state_dbg
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(WORD_DEPTH - 1);

  clr_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we = !RST;
        if (cnt == LAST) state_nxt = ST_READY;
        else             cnt_nxt   = cnt + 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = RST || (state == ST_CLEAR);
  assign clr_addr  = cnt;
  assign state_dbg = state;

endmodule

// File: rtl/ra1sh_v2.sv
// Parametrised single-port synchronous SRAM with byte-lane writes, selectable
// read-during-write behaviour, optional output register and post-reset clear.
module ra1sh_v2
  import ra1sh_pkg::*;
#(
  parameter int BITS           = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int WORD_DEPTH     = 8192,
  parameter int ADDR_WIDTH     = 13,
  parameter int WRITE_MODE     = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         CEN,
  input  logic                         WEN,
  input  logic [BITS/BYTE_WIDTH-1:0]   BWEN,
  input  logic [ADDR_WIDTH-1:0]        A,
  input  logic [BITS-1:0]              D,
  input  logic                         OEN,
  output logic [BITS-1:0]              Q,
  output logic                         BUSY
);

  localparam int NB = BITS / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(WORD_DEPTH);

  if (BITS % BYTE_WIDTH != 0) begin : g_bad_lanes
    $error("ra1sh_v2: BITS must be a multiple of BYTE_WIDTH");
  end
  if (BITS > MAX_BITS) begin : g_bad_bits
    $error("ra1sh_v2: BITS exceeds merge helper width");
  end
  if (WORD_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("ra1sh_v2: WORD_DEPTH does not fit in ADDR_WIDTH");
  end
  if (WRITE_MODE < 0 || WRITE_MODE > 2) begin : g_bad_mode
    $error("ra1sh_v2: WRITE_MODE must be 0, 1 or 2");
  end

  logic [BITS-1:0]       mem [WORD_DEPTH];
  logic [BITS-1:0]       q_reg, q_sel;
  logic [BITS-1:0]       old_w, merged_w;
  logic                  in_range, acc, clr_we, clr_busy;
  logic [ADDR_WIDTH-1:0] clr_addr;
  clr_state_t            clr_state;
  logic [NB-1:0]         bwen_n;

  ra1sh_v2_clr #(
    .WORD_DEPTH    (WORD_DEPTH),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clr (
    .CLK      (CLK),
    .RST      (RST),
    .busy     (clr_busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we),
    .state_dbg(clr_state)
  );

  // An access is taken on any rising edge where CEN is low and the sequencer
  // is READY with RST low; there is no backpressure, BUSY simply drops it.
  assign acc      = (clr_state == ST_READY) && !RST && !CEN;
  assign in_range = ({1'b0, A} < DEPTH_W);
  assign old_w    = in_range ? mem[A] : '0;
  assign bwen_n   = BWEN;
  assign merged_w = BITS'(byte_merge(word_t'(old_w), word_t'(D), word_t'(bwen_n), BYTE_WIDTH));

  always_ff @(posedge CLK) begin
    if (clr_we)                          mem[clr_addr] <= '0;
    else if (acc && !WEN && in_range)    mem[A]        <= merged_w;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_reg <= '0;
    end else if (acc) begin
      if (WEN)                                  q_reg <= old_w;
      else if (WRITE_MODE == WM_WRITE_THROUGH)  q_reg <= in_range ? merged_w : '0;
      else if (WRITE_MODE == WM_READ_FIRST)     q_reg <= old_w;
    end
  end

  if (OUT_REG != 0) begin : g_pipe
    logic [BITS-1:0] q_pipe;
    always_ff @(posedge CLK) begin
      if (RST) q_pipe <= '0;
      else     q_pipe <= q_reg;
    end
    assign q_sel = q_pipe;
  end else begin : g_nopipe
    assign q_sel = q_reg;
  end

  assign Q    = OEN ? '0 : q_sel;
  assign BUSY = clr_busy;

endmodule

// File: tb/tb_ra1sh_v2.sv
// Directed bench for ra1sh_v2: five configurations share one stimulus stream
// and are checked against hand-computed values.
module tb_ra1sh_v2;

  logic        CLK = 1'b0;
  logic        RST, CEN, WEN, OEN;
  logic [3:0]  BWEN, A;
  logic [31:0] D;
  logic [31:0] q0, q1, q2, q3, q4;
  logic        busy0, busy1, busy2, busy3, busy4;

  int n_total = 0;
  int n_bad   = 0;
  int n, n4;
  logic [31:0] exp_q[$];

  always #5 CLK = ~CLK;

  // d0: write-through, d1: read-first, d2: no-change, d3: output register, d4: depth 12
  ra1sh_v2 #(.BITS(32), .BYTE_WIDTH(8), .WORD_DEPTH(16), .ADDR_WIDTH(4), .WRITE_MODE(0),
             .OUT_REG(0), .CLEAR_ON_RESET(1)) d0 (
    .CLK(CLK), .RST(RST), .CEN(CEN), .WEN(WEN), .BWEN(BWEN), .A(A), .D(D), .OEN(OEN),
    .Q(q0), .BUSY(busy0));
  ra1sh_v2 #(.BITS(32), .BYTE_WIDTH(8), .WORD_DEPTH(16), .ADDR_WIDTH(4), .WRITE_MODE(1),
             .OUT_REG(0), .CLEAR_ON_RESET(1)) d1 (
    .CLK(CLK), .RST(RST), .CEN(CEN), .WEN(WEN), .BWEN(BWEN), .A(A), .D(D), .OEN(OEN),
    .Q(q1), .BUSY(busy1));
  ra1sh_v2 #(.BITS(32), .BYTE_WIDTH(8), .WORD_DEPTH(16), .ADDR_WIDTH(4), .WRITE_MODE(2),
             .OUT_REG(0), .CLEAR_ON_RESET(1)) d2 (
    .CLK(CLK), .RST(RST), .CEN(CEN), .WEN(WEN), .BWEN(BWEN), .A(A), .D(D), .OEN(OEN),
    .Q(q2), .BUSY(busy2));
  ra1sh_v2 #(.BITS(32), .BYTE_WIDTH(8), .WORD_DEPTH(16), .ADDR_WIDTH(4), .WRITE_MODE(0),
             .OUT_REG(1), .CLEAR_ON_RESET(1)) d3 (
    .CLK(CLK), .RST(RST), .CEN(CEN), .WEN(WEN), .BWEN(BWEN), .A(A), .D(D), .OEN(OEN),
    .Q(q3), .BUSY(busy3));
  ra1sh_v2 #(.BITS(32), .BYTE_WIDTH(8), .WORD_DEPTH(12), .ADDR_WIDTH(4), .WRITE_MODE(0),
             .OUT_REG(0), .CLEAR_ON_RESET(1)) d4 (
    .CLK(CLK), .RST(RST), .CEN(CEN), .WEN(WEN), .BWEN(BWEN), .A(A), .D(D), .OEN(OEN),
    .Q(q4), .BUSY(busy4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] bw);
    CEN = 1'b0; WEN = 1'b0; A = a; D = d; BWEN = bw;
    tick();
    CEN = 1'b1; WEN = 1'b1; BWEN = 4'hF;
  endtask

  task automatic do_rd(input logic [3:0] a);
    CEN = 1'b0; WEN = 1'b1; A = a;
    tick();
    CEN = 1'b1;
  endtask

  // Counts cycles with busy0 high starting now; bounded so a stuck BUSY cannot hang.
  task automatic wait_ready(output int cnt0, output int cnt4);
    cnt0 = 0;
    cnt4 = 0;
    while (busy0 && cnt0 < 100) begin
      cnt0++;
      if (busy4) cnt4++;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; CEN = 1'b1; WEN = 1'b1; OEN = 1'b0; BWEN = 4'hF; A = '0; D = '0;
    #1;
    check("busy_in_rst", 32'(busy0), 32'd1);
    tick();
    RST = 1'b0;
    #1;
    check("rst_q0", q0, 32'h0);
    check("rst_q3", q3, 32'h0);

    wait_ready(n, n4);
    check("clear_busy_cycles", 32'(n + 1), 32'd17);
    check("clear_busy_cycles_d12", 32'(n4 + 1), 32'd13);
    check("busy_low_d4", 32'(busy4), 32'd0);

    for (int i = 0; i < 16; i++) begin
      do_rd(4'(i));
      check("clr_rd_d0", q0, 32'h0);
      check("clr_rd_d4", q4, 32'h0);
    end

    // partial-lane write
    do_wr(4'd5, 32'hAABBCCDD, 4'b0000);
    check("wr_full_wt", q0, 32'hAABBCCDD);
    check("wr_full_rf", q1, 32'h0);
    do_wr(4'd5, 32'h11223344, 4'b1010);
    check("wr_lane_wt", q0, 32'hAA22CC44);
    check("wr_lane_rf", q1, 32'hAABBCCDD);
    do_rd(4'd5);
    check("rd_lane_d0", q0, 32'hAA22CC44);
    check("rd_lane_d4", q4, 32'hAA22CC44);

    // read-during-write modes
    do_wr(4'd3, 32'h12345678, 4'b0000);
    do_rd(4'd5);
    check("pre_nc", q2, 32'hAA22CC44);
    do_wr(4'd3, 32'hDEADBEEF, 4'b0000);
    check("mode_wt", q0, 32'hDEADBEEF);
    check("mode_rf", q1, 32'h12345678);
    check("mode_nc", q2, 32'hAA22CC44);
    do_rd(4'd3);
    check("wr_then_rd_wt", q0, 32'hDEADBEEF);
    check("wr_then_rd_rf", q1, 32'hDEADBEEF);
    check("wr_then_rd_nc", q2, 32'hDEADBEEF);

    // output register pipeline and OEN gating
    do_wr(4'd1, 32'h1, 4'b0000);
    do_wr(4'd2, 32'h2, 4'b0000);
    do_wr(4'd3, 32'h3, 4'b0000);
    CEN = 1'b0; WEN = 1'b1;
    A = 4'd1; tick();
    A = 4'd2; tick();
    check("pipe_a1", q3, 32'h1);
    check("nopipe_a2", q0, 32'h2);
    A = 4'd3; tick();
    check("pipe_a2", q3, 32'h2);
    OEN = 1'b1;
    #1;
    check("oen_q3", q3, 32'h0);
    check("oen_q0", q0, 32'h0);
    OEN = 1'b0;
    #1;
    check("oen_release", q3, 32'h2);
    CEN = 1'b1;
    tick();
    check("pipe_a3", q3, 32'h3);
    tick();
    check("pipe_hold", q3, 32'h3);

    // out-of-range on the 12-word instance
    do_wr(4'd13, 32'h0000FFFF, 4'b0000);
    do_rd(4'd13);
    check("oor_rd_d4", q4, 32'h0);
    check("inrange_rd_d0", q0, 32'h0000FFFF);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h3);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hAA22CC44);
    for (int i = 6; i < 12; i++) exp_q.push_back(32'h0);
    for (int i = 0; i < 12; i++) begin
      do_rd(4'(i));
      check("oor_mem_d4", q4, exp_q.pop_front());
    end

    // reset in the middle of the clear sweep
    RST = 1'b1; tick(); RST = 1'b0;
    #1;
    check("reclear_busy", 32'(busy0), 32'd1);
    repeat (5) tick();
    RST = 1'b1; tick(); RST = 1'b0;
    #1;
    wait_ready(n, n4);
    check("restart_cycles", 32'(n), 32'd16);

    // reset during a write
    do_wr(4'd2, 32'h00000055, 4'b0000);
    do_rd(4'd2);
    check("pre_rst_rd", q0, 32'h55);
    CEN = 1'b0; WEN = 1'b0; A = 4'd2; D = 32'h00000099; BWEN = 4'b0000; RST = 1'b1;
    tick();
    RST = 1'b0; CEN = 1'b1; WEN = 1'b1; BWEN = 4'hF;
    #1;
    check("rst_wr_q0", q0, 32'h0);
    check("rst_wr_q3", q3, 32'h0);
    check("rst_wr_busy", 32'(busy0), 32'd1);
    wait_ready(n, n4);
    check("rst_wr_cycles", 32'(n), 32'd16);
    do_rd(4'd2);
    check("rst_wr_mem2", q0, 32'h0);
    do_rd(4'd5);
    check("rst_wr_mem5", q0, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
